// File: rtl/rs_branch.sv
// Branch reservation queue: in-order circular FIFO that captures branch ops at dispatch,
// wakes operands from the CDB and issues the head entry to the branch unit.
module rs_branch #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [1:0]       disp_branch_type,
   input  logic             disp_gate_sel,
   input  logic [31:0]      disp_pc,
   input  logic [31:0]      disp_imm,
   input  logic             disp_rs1_ready,
   input  logic [31:0]      disp_rs1_val,
   input  logic [TAG_W-1:0] disp_rs1_tag,
   input  logic             disp_rs2_ready,
   input  logic [31:0]      disp_rs2_val,
   input  logic [TAG_W-1:0] disp_rs2_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   input  logic             flush,
   output logic             issue_valid,
   input  logic             fu_ready,
   output logic             branch,
   output logic [1:0]       branch_type,
   output logic             branch_gate_sel,
   output logic [31:0]      reg_a,
   output logic [31:0]      reg_b,
   output logic [31:0]      current_pc,
   output logic [31:0]      imm
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   logic [DEPTH-1:0] ent_valid, rs1_rdy, rs2_rdy, gate_sel;
   logic [1:0]       btype   [DEPTH];
   logic [31:0]      pc      [DEPTH];
   logic [31:0]      imm_q   [DEPTH];
   logic [31:0]      rs1_val [DEPTH];
   logic [31:0]      rs2_val [DEPTH];
   logic [TAG_W-1:0] rs1_tag [DEPTH];
   logic [TAG_W-1:0] rs2_tag [DEPTH];

   logic push, pop, rs1_byp, rs2_byp;

   // Full blocks dispatch even if the head pops this cycle.
   assign disp_ready  = (count < FULL) && !flush;
   assign issue_valid = (count != '0) && rs1_rdy[head] && rs2_rdy[head] && !flush;
   assign push        = disp_valid && disp_ready;
   assign pop         = issue_valid && fu_ready;
   assign rs1_byp     = !disp_rs1_ready && cdb_valid && (cdb_tag == disp_rs1_tag);
   assign rs2_byp     = !disp_rs2_ready && cdb_valid && (cdb_tag == disp_rs2_tag);

   assign branch          = issue_valid;
   assign branch_type     = btype[head];
   assign branch_gate_sel = gate_sel[head];
   assign reg_a           = rs1_val[head];
   assign reg_b           = rs2_val[head];
   assign current_pc      = pc[head];
   assign imm             = imm_q[head];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         rs1_rdy   <= '0;
         rs2_rdy   <= '0;
         gate_sel  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            btype[i]   <= '0;
            pc[i]      <= '0;
            imm_q[i]   <= '0;
            rs1_val[i] <= '0;
            rs2_val[i] <= '0;
            rs1_tag[i] <= '0;
            rs2_tag[i] <= '0;
         end
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent_valid[i] && !rs1_rdy[i] && (rs1_tag[i] == cdb_tag)) begin
                  rs1_rdy[i] <= 1'b1;
                  rs1_val[i] <= cdb_value;
               end
               if (ent_valid[i] && !rs2_rdy[i] && (rs2_tag[i] == cdb_tag)) begin
                  rs2_rdy[i] <= 1'b1;
                  rs2_val[i] <= cdb_value;
               end
            end
         end
         if (push) begin
            ent_valid[tail] <= 1'b1;
            btype[tail]     <= disp_branch_type;
            gate_sel[tail]  <= disp_gate_sel;
            pc[tail]        <= disp_pc;
            imm_q[tail]     <= disp_imm;
            rs1_rdy[tail]   <= disp_rs1_ready || rs1_byp;
            rs1_val[tail]   <= rs1_byp ? cdb_value : disp_rs1_val;
            rs1_tag[tail]   <= disp_rs1_tag;
            rs2_rdy[tail]   <= disp_rs2_ready || rs2_byp;
            rs2_val[tail]   <= rs2_byp ? cdb_value : disp_rs2_val;
            rs2_tag[tail]   <= disp_rs2_tag;
            tail            <= tail + PTR_W'(1);
         end
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_branch.sv
// Directed self-checking bench for rs_branch: dispatch, wakeup, ordering, backpressure,
// bypass, flush and reset scenarios with hand-computed expectations.
module tb_rs_branch;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        disp_valid, disp_ready;
   logic [1:0]  disp_branch_type;
   logic        disp_gate_sel;
   logic [31:0] disp_pc, disp_imm;
   logic        disp_rs1_ready, disp_rs2_ready;
   logic [31:0] disp_rs1_val, disp_rs2_val;
   logic [4:0]  disp_rs1_tag, disp_rs2_tag;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        flush, issue_valid, fu_ready, branch, branch_gate_sel;
   logic [1:0]  branch_type;
   logic [31:0] reg_a, reg_b, current_pc, imm;

   int total = 0;
   int passed = 0;

   always #5 CLK = ~CLK;

   rs_branch #(.DEPTH(4), .TAG_W(5)) dut (
      .CLK(CLK), .nRST(nRST),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_branch_type(disp_branch_type), .disp_gate_sel(disp_gate_sel),
      .disp_pc(disp_pc), .disp_imm(disp_imm),
      .disp_rs1_ready(disp_rs1_ready), .disp_rs1_val(disp_rs1_val),
      .disp_rs1_tag(disp_rs1_tag),
      .disp_rs2_ready(disp_rs2_ready), .disp_rs2_val(disp_rs2_val),
      .disp_rs2_tag(disp_rs2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .flush(flush), .issue_valid(issue_valid), .fu_ready(fu_ready),
      .branch(branch), .branch_type(branch_type), .branch_gate_sel(branch_gate_sel),
      .reg_a(reg_a), .reg_b(reg_b), .current_pc(current_pc), .imm(imm)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      disp_valid = 0; disp_branch_type = 0; disp_gate_sel = 0; disp_pc = 0; disp_imm = 0;
      disp_rs1_ready = 0; disp_rs1_val = 0; disp_rs1_tag = 0;
      disp_rs2_ready = 0; disp_rs2_val = 0; disp_rs2_tag = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; flush = 0;
   endtask

   // Drives a dispatch request; a tag of 0 with rdy=1 means the value is ready.
   task automatic drive_disp(input logic [1:0] bt, input logic [31:0] p, input logic [31:0] im,
                             input logic r1, input logic [31:0] v1, input logic [4:0] t1,
                             input logic r2, input logic [31:0] v2, input logic [4:0] t2);
      disp_valid = 1; disp_branch_type = bt; disp_gate_sel = bt[0]; disp_pc = p; disp_imm = im;
      disp_rs1_ready = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
      disp_rs2_ready = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
   endtask

   task automatic test_reset();
      idle_inputs(); fu_ready = 0; nRST = 0;
      #2;
      total++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); else passed++;
      total++; if (branch !== 1'b0) $display("FAIL reset_branch got=%b exp=0", branch); else passed++;
      total++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); else passed++;
      total++; if ({reg_a, reg_b, current_pc, imm, branch_type, branch_gate_sel} !== '0)
         $display("FAIL reset_issue_data got=%h/%h/%h/%h exp=0", reg_a, reg_b, current_pc, imm);
      else passed++;
      tick(); nRST = 1; tick();
   endtask

   task automatic test_ready_dispatch();
      fu_ready = 1;
      drive_disp(2'd0, 32'd0, 32'd100, 1, 32'd10, 0, 1, 32'd10, 0);
      #1;
      total++; if (issue_valid !== 1'b0) $display("FAIL ready_no_bypass got=%b exp=0", issue_valid); else passed++;
      tick(); idle_inputs(); #1;
      total++; if (issue_valid !== 1'b1 || branch !== 1'b1)
         $display("FAIL ready_issue got=%b/%b exp=1/1", issue_valid, branch);
      else passed++;
      total++; if ({reg_a, reg_b, current_pc, imm} !== {32'd10, 32'd10, 32'd0, 32'd100})
         $display("FAIL ready_data got=%0d/%0d/%0d/%0d exp=10/10/0/100", reg_a, reg_b, current_pc, imm);
      else passed++;
      tick();
      total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1)
         $display("FAIL ready_drained got=%b/%b exp=0/1", issue_valid, disp_ready);
      else passed++;
   endtask

   task automatic test_wakeup();
      fu_ready = 1;
      drive_disp(2'd2, 32'h20, 32'h8, 1, 32'd8, 0, 0, 32'd0, 5'd3);
      tick(); idle_inputs();
      total++; if (issue_valid !== 1'b0) $display("FAIL wake_waiting got=%b exp=0", issue_valid); else passed++;
      cdb_valid = 1; cdb_tag = 5; cdb_value = 32'd99;
      tick(); idle_inputs();
      total++; if (issue_valid !== 1'b0) $display("FAIL wake_wrong_tag got=%b exp=0", issue_valid); else passed++;
      cdb_valid = 1; cdb_tag = 3; cdb_value = 32'd10;
      #1;
      total++; if (issue_valid !== 1'b0) $display("FAIL wake_same_cycle got=%b exp=0", issue_valid); else passed++;
      tick(); idle_inputs(); #1;
      total++; if (issue_valid !== 1'b1 || reg_a !== 32'd8 || reg_b !== 32'd10 || branch_type !== 2'd2)
         $display("FAIL wake_issue got=%b a=%0d b=%0d t=%0d exp=1 a=8 b=10 t=2",
                  issue_valid, reg_a, reg_b, branch_type);
      else passed++;
      tick();
      total++; if (issue_valid !== 1'b0) $display("FAIL wake_drained got=%b exp=0", issue_valid); else passed++;
   endtask

   task automatic test_in_order();
      fu_ready = 0;
      drive_disp(2'd1, 32'h100, 32'd0, 0, 32'd0, 5'd7, 1, 32'd1, 0);
      tick();
      drive_disp(2'd3, 32'h200, 32'd0, 1, 32'd2, 0, 1, 32'd3, 0);
      tick(); idle_inputs(); fu_ready = 1; #1;
      total++; if (issue_valid !== 1'b0) $display("FAIL order_blocked got=%b exp=0", issue_valid); else passed++;
      tick();
      total++; if (issue_valid !== 1'b0) $display("FAIL order_still_blocked got=%b exp=0", issue_valid); else passed++;
      cdb_valid = 1; cdb_tag = 7; cdb_value = 32'd5;
      tick(); idle_inputs(); #1;
      total++; if (issue_valid !== 1'b1 || current_pc !== 32'h100 || reg_a !== 32'd5)
         $display("FAIL order_head got=%b pc=%h a=%0d exp=1 pc=100 a=5", issue_valid, current_pc, reg_a);
      else passed++;
      tick();
      total++; if (issue_valid !== 1'b1 || current_pc !== 32'h200 || branch_type !== 2'd3)
         $display("FAIL order_young got=%b pc=%h t=%0d exp=1 pc=200 t=3", issue_valid, current_pc, branch_type);
      else passed++;
      tick();
      total++; if (issue_valid !== 1'b0) $display("FAIL order_drained got=%b exp=0", issue_valid); else passed++;
   endtask

   task automatic test_backpressure();
      fu_ready = 0;
      for (int i = 0; i < 4; i++) begin
         drive_disp(2'd0, 32'(4 * i), 32'(i), 1, 32'(i), 0, 1, 32'(i + 1), 0);
         #1;
         total++; if (disp_ready !== 1'b1) $display("FAIL bp_ready_%0d got=%b exp=1", i, disp_ready); else passed++;
         tick();
      end
      total++; if (disp_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", disp_ready); else passed++;
      drive_disp(2'd0, 32'd16, 32'd4, 1, 32'd0, 0, 1, 32'd0, 0);
      tick(); idle_inputs(); #1;
      total++; if (issue_valid !== 1'b1 || current_pc !== 32'd0 || imm !== 32'd0)
         $display("FAIL bp_hold got=%b pc=%0d imm=%0d exp=1 pc=0 imm=0", issue_valid, current_pc, imm);
      else passed++;
      fu_ready = 1; #1;
      total++; if (disp_ready !== 1'b0) $display("FAIL bp_pop_no_free got=%b exp=0", disp_ready); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++; if (issue_valid !== 1'b1 || current_pc !== 32'(4 * i) || reg_b !== 32'(i + 1))
            $display("FAIL bp_issue_%0d got=%b pc=%0d b=%0d exp=1 pc=%0d b=%0d",
                     i, issue_valid, current_pc, reg_b, 4 * i, i + 1);
         else passed++;
         tick();
      end
      total++; if (issue_valid !== 1'b0) $display("FAIL bp_fifth_dropped got=%b exp=0", issue_valid); else passed++;
   endtask

   task automatic test_bypass();
      fu_ready = 1;
      drive_disp(2'd1, 32'h300, 32'd0, 0, 32'd0, 5'd2, 1, 32'd0, 0);
      cdb_valid = 1; cdb_tag = 2; cdb_value = 32'h8000_0000;
      tick(); idle_inputs(); #1;
      total++; if (issue_valid !== 1'b1 || reg_a !== 32'h8000_0000)
         $display("FAIL bypass_issue got=%b a=%h exp=1 a=80000000", issue_valid, reg_a);
      else passed++;
      tick();
      total++; if (issue_valid !== 1'b0) $display("FAIL bypass_drained got=%b exp=0", issue_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      fu_ready = 1;
      for (int i = 0; i < 3; i++) begin
         drive_disp(2'd0, 32'h40 + 32'(4 * i), 32'd0, 1, 32'd0, 0, 1, 32'd0, 0);
         tick();
         total++; if (issue_valid !== 1'b1 || current_pc !== 32'h40 + 32'(4 * i))
            $display("FAIL b2b_issue_%0d got=%b pc=%h exp=1 pc=%h", i, issue_valid, current_pc, 32'h40 + 4 * i);
         else passed++;
      end
      idle_inputs();
      tick();
      total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1)
         $display("FAIL b2b_drained got=%b/%b exp=0/1", issue_valid, disp_ready);
      else passed++;
   endtask

   task automatic test_flush();
      fu_ready = 0;
      for (int i = 0; i < 3; i++) begin
         drive_disp(2'd0, 32'h500 + 32'(i), 32'd0, 1, 32'd0, 0, 1, 32'd0, 0);
         tick();
      end
      drive_disp(2'd0, 32'h600, 32'd0, 1, 32'd0, 0, 1, 32'd0, 0);
      flush = 1; #1;
      total++; if (disp_ready !== 1'b0 || issue_valid !== 1'b0)
         $display("FAIL flush_comb got=%b/%b exp=0/0", disp_ready, issue_valid);
      else passed++;
      tick(); idle_inputs(); fu_ready = 1; #1;
      total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1)
         $display("FAIL flush_cleared got=%b/%b exp=0/1", issue_valid, disp_ready);
      else passed++;
      tick();
      total++; if (issue_valid !== 1'b0) $display("FAIL flush_dispatch_dropped got=%b exp=0", issue_valid); else passed++;
   endtask

   task automatic test_reset_mid();
      fu_ready = 0;
      for (int i = 0; i < 2; i++) begin
         drive_disp(2'd3, 32'h700, 32'h9, 1, 32'h55, 0, 1, 32'h66, 0);
         tick();
      end
      idle_inputs();
      total++; if (issue_valid !== 1'b1) $display("FAIL rst_mid_pre got=%b exp=1", issue_valid); else passed++;
      #2 nRST = 0; #1;
      total++; if (issue_valid !== 1'b0 || reg_a !== 32'd0 || current_pc !== 32'd0)
         $display("FAIL rst_mid_async got=%b a=%h pc=%h exp=0 a=0 pc=0", issue_valid, reg_a, current_pc);
      else passed++;
      #2 nRST = 1; fu_ready = 1;
      tick();
      total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1)
         $display("FAIL rst_mid_after got=%b/%b exp=0/1", issue_valid, disp_ready);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_ready_dispatch();
      test_wakeup();
      test_in_order();
      test_backpressure();
      test_bypass();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
